// File: rtl/snake_pkg.sv
// Shared constants for the snake game: direction codes, PS/2 scan codes and
// the state encodings used by the keyboard decoder.
package snake_pkg;

  localparam logic [3:0] KEY_UP    = 4'b0001;
  localparam logic [3:0] KEY_DOWN  = 4'b0010;
  localparam logic [3:0] KEY_LEFT  = 4'b0100;
  localparam logic [3:0] KEY_RIGHT = 4'b1000;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Code FSM: plain keys, after E0, after F0, after E0 F0
  localparam logic [1:0] C_NORM    = 2'd0;
  localparam logic [1:0] C_EXT     = 2'd1;
  localparam logic [1:0] C_BRK     = 2'd2;
  localparam logic [1:0] C_EXT_BRK = 2'd3;

  // Frame FSM: waiting for a start bit, or collecting bits
  localparam logic [0:0] F_IDLE  = 1'b0;
  localparam logic [0:0] F_SHIFT = 1'b1;

  // Direction for a WASD make code, zero when the byte is not one of them
  function automatic logic [3:0] wasdKey(input logic [7:0] sc);
    logic [3:0] k;
    k = 4'b0000;
    case (sc)
      SC_W:    k = KEY_UP;
      SC_S:    k = KEY_DOWN;
      SC_A:    k = KEY_LEFT;
      SC_D:    k = KEY_RIGHT;
      default: k = 4'b0000;
    endcase
    return k;
  endfunction

  // Direction for an extended (E0-prefixed) arrow code, zero otherwise
  function automatic logic [3:0] arrowKey(input logic [7:0] sc);
    logic [3:0] k;
    k = 4'b0000;
    case (sc)
      SC_UP:    k = KEY_UP;
      SC_DOWN:  k = KEY_DOWN;
      SC_LEFT:  k = KEY_LEFT;
      SC_RIGHT: k = KEY_RIGHT;
      default:  k = 4'b0000;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 pins in, game-facing direction/start/error outputs back.
// master = keyboard/board side, slave = decoder side.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key;
  logic       key_valid;
  logic       start;
  logic       frame_err;

  modport master (output ps2_clk, output ps2_data,
                  input key, input key_valid, input start, input frame_err);
  modport slave  (input ps2_clk, input ps2_data,
                  output key, output key_valid, output start, output frame_err);
endinterface

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: synchronizes and debounces the raw pins, finds clock
// falling edges and assembles 11-bit frames into bytes. byte_rdy_o and
// frame_err_o are combinational strobes in the cycle of the deciding edge.
module ps2_frame_rx
  import snake_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_rdy_o,
  output logic       frame_err_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clkSync_q, dataSync_q;
  logic          filt_q, fe_q;
  logic [FW-1:0] filtCnt_q;
  logic [0:0]    state_q, state_d;
  logic [3:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] toCnt_q, toCnt_d;
  logic          bitIn, timeout;

  // Two-flop synchronizers; idle-high so a reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk_i};
      dataSync_q <= {dataSync_q[0], ps2_data_i};
    end
  end

  // Clock filter: flip only after FILTER_LEN agreeing samples; flag 1->0 flips
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q    <= 1'b1;
      filtCnt_q <= '0;
      fe_q      <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      if (clkSync_q[1] == filt_q) begin
        filtCnt_q <= '0;
      end else if (filtCnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q    <= clkSync_q[1];
        filtCnt_q <= '0;
        fe_q      <= filt_q;
      end else begin
        filtCnt_q <= filtCnt_q + 1'b1;
      end
    end
  end

  assign bitIn   = dataSync_q[1];
  assign timeout = (state_q == F_SHIFT) && (toCnt_q == TW'(TIMEOUT_CYC - 1));
  assign byte_o  = shift_q;

  // Frame FSM next state; an edge always beats a coincident timeout
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    toCnt_d     = toCnt_q;
    byte_rdy_o  = 1'b0;
    frame_err_o = 1'b0;
    if (fe_q) begin
      toCnt_d = '0;
      if (state_q == F_IDLE) begin
        if (!bitIn) begin
          state_d  = F_SHIFT;
          bitCnt_d = 4'd0;
        end
      end else begin
        bitCnt_d = bitCnt_q + 4'd1;
        if (bitCnt_q < 4'd8) begin
          shift_d = {bitIn, shift_q[7:1]};
        end else if (bitCnt_q == 4'd8) begin
          par_d = bitIn;
        end else begin
          state_d  = F_IDLE;
          bitCnt_d = 4'd0;
          if (bitIn && ((^shift_q) ^ par_q)) byte_rdy_o = 1'b1;
          else                               frame_err_o = 1'b1;
        end
      end
    end else if (state_q == F_SHIFT) begin
      if (timeout) begin
        state_d     = F_IDLE;
        bitCnt_d    = 4'd0;
        toCnt_d     = '0;
        frame_err_o = 1'b1;
      end else begin
        toCnt_d = toCnt_q + 1'b1;
      end
    end
  end

  // Frame FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= F_IDLE;
      bitCnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      toCnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      toCnt_q  <= toCnt_d;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to snake direction decoder. Turns received bytes into a held
// one-hot direction, a start pulse for Enter and an error pulse for bad frames.
module ps2_key_decoder
  import snake_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input logic               clk,
  input logic               rst,
  ps2_key_decoder_if.slave  bus
);

  logic [7:0] rxByte;
  logic       rxRdy, rxErr;
  logic [1:0] cState_q, cState_d;
  logic [3:0] key_q, key_d;
  logic       keyValid_q, keyValid_d;
  logic       start_q, start_d;
  logic       frameErr_q, frameErr_d;
  logic [3:0] wasd, arrow;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (bus.ps2_clk),
    .ps2_data_i (bus.ps2_data),
    .byte_o     (rxByte),
    .byte_rdy_o (rxRdy),
    .frame_err_o(rxErr)
  );

  assign wasd  = wasdKey(rxByte);
  assign arrow = arrowKey(rxByte);

  // Code FSM: track E0/F0 prefixes and decide which byte produces an output
  always_comb begin
    cState_d   = cState_q;
    key_d      = key_q;
    keyValid_d = 1'b0;
    start_d    = 1'b0;
    frameErr_d = rxErr;
    if (rxErr) begin
      cState_d = C_NORM;
    end else if (rxRdy) begin
      case (cState_q)
        C_NORM: begin
          if (rxByte == SC_EXT) begin
            cState_d = C_EXT;
          end else if (rxByte == SC_BRK) begin
            cState_d = C_BRK;
          end else if (wasd != 4'b0000) begin
            key_d      = wasd;
            keyValid_d = 1'b1;
          end else if (rxByte == SC_ENTER) begin
            start_d = 1'b1;
          end
        end
        C_EXT: begin
          if (arrow != 4'b0000) begin
            key_d      = arrow;
            keyValid_d = 1'b1;
            cState_d   = C_NORM;
          end else if (rxByte == SC_BRK) begin
            cState_d = C_EXT_BRK;
          end else begin
            cState_d = C_NORM;
          end
        end
        default: cState_d = C_NORM;
      endcase
    end
  end

  // Code FSM state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cState_q   <= C_NORM;
      key_q      <= KEY_RIGHT;
      keyValid_q <= 1'b0;
      start_q    <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      cState_q   <= cState_d;
      key_q      <= key_d;
      keyValid_q <= keyValid_d;
      start_q    <= start_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign bus.key       = key_q;
  assign bus.key_valid = keyValid_q;
  assign bus.start     = start_q;
  assign bus.frame_err = frameErr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: drives PS/2 frames, predicts every output pulse
// with a scan-code table model and checks pulses from a separate monitor.
module tb_ps2_key_decoder;

  localparam int FILT = 8;
  localparam int TOUT = 1000;
  localparam int HP   = 20;

  typedef enum int {EV_KEY, EV_START, EV_ERR} evKind_e;
  typedef struct {
    evKind_e    kind;
    logic [3:0] key;
    int         t0;
    int         lo;
    int         hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   eventsSeen = 0;
  int   lastFall = 0;

  exp_t       sbq[$];
  logic [3:0] mKey;
  bit         mExt, mBrk;
  logic [3:0] plainMap [logic [7:0]];
  logic [3:0] extMap   [logic [7:0]];

  ps2_key_decoder_if bus();

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used for latency windows
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pushExp(input evKind_e k, input int t0, input int lo, input int hi);
    exp_t e;
    e.kind = k; e.key = mKey; e.t0 = t0; e.lo = lo; e.hi = hi;
    sbq.push_back(e);
  endtask

  // Reference: what a keyboard byte means given any pending E0 / F0 prefix
  task automatic modelByte(input logic [7:0] b, input int t0);
    if (mBrk) begin
      mBrk = 0;
      mExt = 0;
    end else if (mExt) begin
      mExt = 0;
      if (extMap.exists(b)) begin
        mKey = extMap[b];
        pushExp(EV_KEY, t0, FILT, FILT + 8);
      end else if (b == 8'hF0) begin
        mBrk = 1;
      end
    end else if (b == 8'hE0) begin
      mExt = 1;
    end else if (b == 8'hF0) begin
      mBrk = 1;
    end else if (plainMap.exists(b)) begin
      mKey = plainMap[b];
      pushExp(EV_KEY, t0, FILT, FILT + 8);
    end else if (b == 8'h5A) begin
      pushExp(EV_START, t0, FILT, FILT + 8);
    end
  endtask

  task automatic modelErr(input int t0, input int lo, input int hi);
    mExt = 0;
    mBrk = 0;
    pushExp(EV_ERR, t0, lo, hi);
  endtask

  // Sends the first nbits of an 11-bit frame (start, 8 data LSB first, parity, stop)
  task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit badStop, input int nbits);
    logic [10:0] bits;
    logic        par;
    par  = badPar ? (^b) : ~(^b);
    bits = {~badStop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.ps2_data = bits[i];
      repeat (HP / 2) @(negedge clk);
      bus.ps2_clk = 1'b0;
      lastFall = cyc;
      if (i == 10) begin
        if (badPar || badStop) modelErr(lastFall, FILT, FILT + 8);
        else                   modelByte(b, lastFall);
      end
      repeat (HP) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (HP / 2) @(negedge clk);
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b0, 1'b0, 11);
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (n) @(negedge clk);
    sbq.delete();
    mKey = 4'b1000;
    mExt = 0;
    mBrk = 0;
    rst = 1'b0;
  endtask

  // Monitor: every output pulse must match the oldest predicted event
  task automatic monitorLoop();
    exp_t       e;
    logic [2:0] pulses;
    logic [2:0] want;
    int         lat;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("key_onehot", {31'd0, $onehot(bus.key)}, 32'd1);
        pulses = {bus.key_valid, bus.start, bus.frame_err};
        if (pulses != 3'b000) begin
          eventsSeen++;
          if (sbq.size() == 0) begin
            checkOutput("unexpected_pulse", {29'd0, pulses}, 32'd0);
          end else begin
            e    = sbq.pop_front();
            lat  = cyc - e.t0;
            want = (e.kind == EV_KEY) ? 3'b100 : (e.kind == EV_START) ? 3'b010 : 3'b001;
            checkOutput("pulse_kind", {29'd0, pulses}, {29'd0, want});
            checkOutput("key_at_pulse", {28'd0, bus.key}, {28'd0, e.key});
            checkOutput("pulse_latency", lat, (lat >= e.lo && lat <= e.hi) ? lat : e.lo);
          end
        end
      end
    end
  endtask

  // Hang guard
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    logic [7:0] pool [12];
    logic [7:0] b;
    int r;

    plainMap[8'h1D] = 4'b0001; plainMap[8'h1B] = 4'b0010;
    plainMap[8'h1C] = 4'b0100; plainMap[8'h23] = 4'b1000;
    extMap[8'h75]   = 4'b0001; extMap[8'h72]   = 4'b0010;
    extMap[8'h6B]   = 4'b0100; extMap[8'h74]   = 4'b1000;
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74,
             8'hE0, 8'hF0, 8'h5A, 8'h00};

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    fork
      monitorLoop();
    join_none
    doReset(5);

    @(negedge clk);
    checkOutput("reset_key", {28'd0, bus.key}, 32'h8);
    checkOutput("reset_pulses", {29'd0, bus.key_valid, bus.start, bus.frame_err}, 32'd0);

    // Reset mid-frame, then a clean W
    applyStimulus(8'h1D, 1'b0, 1'b0, 5);
    doReset(4);
    repeat (30) @(negedge clk);
    checkOutput("midframe_reset_key", {28'd0, bus.key}, 32'h8);
    sendByte(8'h1D);
    checkOutput("key_after_W", {28'd0, bus.key}, 32'h1);

    // Extended arrow make, then extended break
    sendByte(8'h23);
    sendByte(8'hE0); sendByte(8'h75);
    checkOutput("key_after_ext_up", {28'd0, bus.key}, 32'h1);
    seen = eventsSeen;
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
    checkOutput("ext_break_no_pulse", eventsSeen, seen);
    checkOutput("key_after_ext_break", {28'd0, bus.key}, 32'h1);

    // Break of A is swallowed, the following make is not
    sendByte(8'hF0); sendByte(8'h1C);
    checkOutput("key_after_break_A", {28'd0, bus.key}, 32'h1);
    sendByte(8'h1C);
    checkOutput("key_after_A", {28'd0, bus.key}, 32'h4);

    // Bad parity, then a good D
    applyStimulus(8'h23, 1'b1, 1'b0, 11);
    checkOutput("key_after_bad_parity", {28'd0, bus.key}, 32'h4);
    sendByte(8'h23);
    checkOutput("key_after_D", {28'd0, bus.key}, 32'h8);

    // Partial frame abandoned by timeout, then Enter
    applyStimulus(8'h1B, 1'b0, 1'b0, 4);
    modelErr(lastFall, TOUT, TOUT + 40);
    repeat (TOUT + 10) @(negedge clk);
    checkOutput("timeout_drained", sbq.size(), 32'd0);
    sendByte(8'h5A);
    checkOutput("key_after_enter", {28'd0, bus.key}, 32'h8);

    // Short glitch on the clock line must not start a frame
    seen = eventsSeen;
    @(negedge clk);
    bus.ps2_data = 1'b0;
    bus.ps2_clk  = 1'b0;
    repeat (3) @(negedge clk);
    bus.ps2_clk  = 1'b1;
    repeat (5) @(negedge clk);
    bus.ps2_data = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("glitch_no_pulse", eventsSeen, seen);
    sendByte(8'h1B);
    checkOutput("key_after_glitch_S", {28'd0, bus.key}, 32'h2);

    // Randomized traffic against the table model
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      b = pool[$urandom_range(0, 11)];
      if (b == 8'h00) b = 8'($urandom_range(0, 255));
      applyStimulus(b, r < 8, (r >= 8) && (r < 12), 11);
    end

    repeat (60) @(negedge clk);
    checkOutput("scoreboard_drained", sbq.size(), 32'd0);
    checkOutput("final_key", {28'd0, bus.key}, {28'd0, mKey});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
